// File: rtl/ec_point_encoder.sv
`default_nettype none
// ============================================================================
// Module   : ec_point_encoder
// Brief    : Serialises an affine EC point as a SEC1 octet string, MSB first.
//            Optional 16-bit length header: EC_POINT_ENCODER_LEN_HDR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ec_point_encoder #(
  parameter int COORD_BYTES = 32,
  parameter int CNT_W       = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [8*COORD_BYTES-1:0] in_x,
  input  logic [8*COORD_BYTES-1:0] in_y,
  input  logic                     in_inf,
  input  logic [1:0]               in_fmt,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic [CNT_W-1:0]         out_len,
  output logic                     busy,
  output logic                     err
);

  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_PREFIX = 3'd1;
  localparam logic [2:0] c_ST_XBYTES = 3'd2;
  localparam logic [2:0] c_ST_YBYTES = 3'd3;
  localparam logic [2:0] c_ST_ERR    = 3'd4;
`ifdef EC_POINT_ENCODER_LEN_HDR_EN
  localparam logic [2:0] c_ST_HDR    = 3'd5;
  localparam logic [2:0] c_ST_FIRST  = c_ST_HDR;
  localparam int         c_HDR_BYTES = 2;
`else
  localparam logic [2:0] c_ST_FIRST  = c_ST_PREFIX;
  localparam int         c_HDR_BYTES = 0;
`endif

  localparam logic [CNT_W-1:0] c_LEN_INF  = CNT_W'(1 + c_HDR_BYTES);
  localparam logic [CNT_W-1:0] c_LEN_COMP = CNT_W'(1 + COORD_BYTES + c_HDR_BYTES);
  localparam logic [CNT_W-1:0] c_LEN_FULL = CNT_W'(1 + 2*COORD_BYTES + c_HDR_BYTES);
  localparam logic [CNT_W-1:0] c_IDX_TOP  = CNT_W'(COORD_BYTES - 1);

  logic [2:0]               r_state;
  logic [8*COORD_BYTES-1:0] r_x;
  logic [8*COORD_BYTES-1:0] r_y;
  logic                     r_inf;
  logic [1:0]               r_fmt;
  logic [CNT_W-1:0]         r_idx;
  logic [CNT_W-1:0]         r_cnt;
  logic [CNT_W-1:0]         r_len;

  logic                     w_accept;
  logic                     w_fire;
  logic [CNT_W-1:0]         w_len_req;

  assign w_accept = in_valid & in_ready;
  assign w_fire   = out_valid & out_ready;

  always_comb begin
    w_len_req = c_LEN_FULL;
    if (in_inf) begin
      w_len_req = c_LEN_INF;
    end else if (in_fmt == 2'd1) begin
      w_len_req = c_LEN_COMP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_inf   <= 1'b0;
      r_fmt   <= 2'd0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_accept) begin
            r_x   <= in_x;
            r_y   <= in_y;
            r_inf <= in_inf;
            r_fmt <= in_fmt;
            if (!in_inf && in_fmt == 2'd3) begin
              r_state <= c_ST_ERR;
            end else begin
              r_state <= c_ST_FIRST;
              r_len   <= w_len_req;
              r_cnt   <= w_len_req - CNT_W'(1);
`ifdef EC_POINT_ENCODER_LEN_HDR_EN
              r_idx   <= CNT_W'(1);
`endif
            end
          end
        end
`ifdef EC_POINT_ENCODER_LEN_HDR_EN
        c_ST_HDR: begin
          if (w_fire) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_idx == '0) begin
              r_state <= c_ST_PREFIX;
            end else begin
              r_idx <= r_idx - CNT_W'(1);
            end
          end
        end
`endif
        c_ST_PREFIX: begin
          if (w_fire) begin
            r_cnt   <= r_cnt - CNT_W'(1);
            r_idx   <= c_IDX_TOP;
            r_state <= r_inf ? c_ST_IDLE : c_ST_XBYTES;
          end
        end
        c_ST_XBYTES: begin
          if (w_fire) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_idx == '0) begin
              r_idx   <= c_IDX_TOP;
              r_state <= (r_fmt == 2'd1) ? c_ST_IDLE : c_ST_YBYTES;
            end else begin
              r_idx <= r_idx - CNT_W'(1);
            end
          end
        end
        c_ST_YBYTES: begin
          if (w_fire) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_idx == '0) begin
              r_state <= c_ST_IDLE;
            end else begin
              r_idx <= r_idx - CNT_W'(1);
            end
          end
        end
        c_ST_ERR: begin
          r_state <= c_ST_IDLE;
        end
        default: begin
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = (r_state != c_ST_IDLE);
  assign in_ready  = !busy;
  assign err       = (r_state == c_ST_ERR);
  assign out_len   = r_len;
  assign out_valid = (r_state == c_ST_PREFIX) || (r_state == c_ST_XBYTES) ||
`ifdef EC_POINT_ENCODER_LEN_HDR_EN
                     (r_state == c_ST_HDR) ||
`endif
                     (r_state == c_ST_YBYTES);
  // The down-counter reaches zero exactly on the final byte of every format.
  assign out_last  = out_valid && (r_cnt == '0);

`ifdef EC_POINT_ENCODER_LEN_HDR_EN
  logic [15:0] w_hdr_len;
  assign w_hdr_len = 16'(r_len - CNT_W'(c_HDR_BYTES));
`endif

  always_comb begin
    out_data = 8'h00;
    case (r_state)
`ifdef EC_POINT_ENCODER_LEN_HDR_EN
      c_ST_HDR: out_data = r_idx[0] ? w_hdr_len[15:8] : w_hdr_len[7:0];
`endif
      c_ST_PREFIX: begin
        if (r_inf) begin
          out_data = 8'h00;
        end else begin
          case (r_fmt)
            2'd0:    out_data = 8'h04;
            2'd1:    out_data = {7'b0000001, r_y[0]};
            default: out_data = {7'b0000011, r_y[0]};
          endcase
        end
      end
      c_ST_XBYTES: out_data = r_x[{r_idx, 3'b000} +: 8];
      c_ST_YBYTES: out_data = r_y[{r_idx, 3'b000} +: 8];
      default:     out_data = 8'h00;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ec_point_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ec_point_encoder
// Brief    : Randomised self-checking bench for ec_point_encoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ec_point_encoder;

  localparam int N     = 32;
  localparam int CNT_W = 8;
  localparam int W     = 8*N;
`ifdef EC_POINT_ENCODER_LEN_HDR_EN
  localparam int HDR   = 2;
`else
  localparam int HDR   = 0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     in_x = '0;
  logic [W-1:0]     in_y = '0;
  logic             in_inf = 1'b0;
  logic [1:0]       in_fmt = 2'd0;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             out_last;
  logic [CNT_W-1:0] out_len;
  logic             busy;
  logic             err;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;

  logic [7:0]       exp_q[$];
  logic [7:0]       got_q[$];
  int               last_idx, stall_bad, bubble, len_bad;
  logic             valid_first, post_valid, post_busy, post_ready, timed_out;
  logic [CNT_W-1:0] len_seen;

  ec_point_encoder #(.COORD_BYTES(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_inf(in_inf), .in_fmt(in_fmt),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_len(out_len), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (err) err_seen = err_seen + 1;

  // Reference: SEC1 octet string built directly from the point.
  function automatic void build_exp(input logic [W-1:0] x, input logic [W-1:0] y,
                                    input logic inf, input logic [1:0] fmt);
    int n;
    exp_q.delete();
    if (inf) n = 1;
    else if (fmt == 2'd1) n = 1 + N;
    else n = 1 + 2*N;
`ifdef EC_POINT_ENCODER_LEN_HDR_EN
    exp_q.push_back(8'(n / 256));
    exp_q.push_back(8'(n % 256));
`endif
    if (inf) begin
      exp_q.push_back(8'h00);
      return;
    end
    if (fmt == 2'd0) exp_q.push_back(8'h04);
    else if (fmt == 2'd1) exp_q.push_back(8'(2 + int'(y[0])));
    else exp_q.push_back(8'(6 + int'(y[0])));
    for (int i = N-1; i >= 0; i--) exp_q.push_back(x[8*i +: 8]);
    if (fmt != 2'd1)
      for (int i = N-1; i >= 0; i--) exp_q.push_back(y[8*i +: 8]);
  endfunction

  function automatic int first_diff();
    int m;
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) if (got_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  function automatic logic pick_ready(input int mode, input int k);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (k % 4 == 0) || (k % 4 == 3);
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [W-1:0] rand_coord();
    logic [W-1:0] v;
    for (int i = 0; i < W/32; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Drives one request and records the byte stream; comparisons are made by the callers.
  task automatic encode(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic inf, input logic [1:0] fmt, input int mode);
    int cyc, k;
    logic pend, rdy, done, pl;
    logic [7:0] pd;
    got_q.delete();
    last_idx = -1; stall_bad = 0; bubble = 0; len_bad = 0; timed_out = 1'b0;
    pend = 1'b0; pl = 1'b0; pd = 8'h00;
    cyc = 0;
    while (!in_ready && cyc < 50) begin @(negedge clk); cyc++; end
    in_valid = 1'b1; in_x = x; in_y = y; in_inf = inf; in_fmt = fmt;
    @(negedge clk);
    in_valid = 1'b0; in_x = rand_coord(); in_y = ~y; in_inf = ~inf; in_fmt = 2'($urandom_range(0, 3));
    valid_first = out_valid;
    len_seen = out_len;
    done = 1'b0; k = 0;
    while (!done) begin
      if (k >= 600) begin timed_out = 1'b1; break; end
      rdy = 1'b0;
      if (!out_valid) bubble++;
      else begin
        if (pend && (out_data !== pd || out_last !== pl)) stall_bad++;
        if (out_len !== len_seen) len_bad++;
        rdy = pick_ready(mode, k);
        if (rdy) begin
          if (out_last) begin last_idx = got_q.size(); done = 1'b1; end
          got_q.push_back(out_data);
          pend = 1'b0;
        end else begin
          pend = 1'b1; pd = out_data; pl = out_last;
        end
      end
      out_ready = rdy;
      @(negedge clk);
      k++;
    end
    out_ready = 1'b0;
    post_valid = out_valid; post_busy = busy; post_ready = in_ready;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %02h want 00", out_data); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %0b want 0", out_last); end
    checks++; if (out_len !== '0) begin errors++; $display("FAIL reset_out_len got %0d want 0", out_len); end
    checks++; if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_busy_err got %0b%0b want 00", busy, err); end
  endtask

  task automatic test_uncompressed();
    logic [W-1:0] x, y;
    for (int i = 0; i < N; i++) begin x[8*i +: 8] = 8'(N - i); y[8*i +: 8] = 8'(2*N - i); end
    build_exp(x, y, 1'b0, 2'd0);
    encode(x, y, 1'b0, 2'd0, 0);
    checks++; if (got_q.size() != 65 + HDR) begin errors++; $display("FAIL unc_size got %0d want %0d", got_q.size(), 65 + HDR); end
    checks++; if (got_q[HDR] !== 8'h04 || got_q[HDR+1] !== 8'h01 || got_q[HDR+64] !== 8'h40) begin
      errors++; $display("FAIL unc_ends got %02h %02h %02h want 04 01 40", got_q[HDR], got_q[HDR+1], got_q[HDR+64]); end
    checks++; if (first_diff() != -1) begin errors++; $display("FAIL unc_bytes first bad index %0d", first_diff()); end
    checks++; if (last_idx != 64 + HDR) begin errors++; $display("FAIL unc_last got index %0d want %0d", last_idx, 64 + HDR); end
    checks++; if (len_seen !== CNT_W'(65 + HDR) || len_bad != 0) begin errors++; $display("FAIL unc_len got %0d (unstable %0d) want %0d", len_seen, len_bad, 65 + HDR); end
    checks++; if (!valid_first || bubble != 0) begin errors++; $display("FAIL unc_timing got first_valid %0b bubbles %0d want 1 0", valid_first, bubble); end
    checks++; if (post_valid !== 1'b0 || post_busy !== 1'b0 || post_ready !== 1'b1) begin
      errors++; $display("FAIL unc_post got valid %0b busy %0b ready %0b want 0 0 1", post_valid, post_busy, post_ready); end
  endtask

  task automatic test_compressed();
    logic [W-1:0] x, y;
    for (int b = 1; b >= 0; b--) begin
      x = {N{8'hAA}};
      y = rand_coord();
      y[0] = 1'(b);
      build_exp(x, y, 1'b0, 2'd1);
      encode(x, y, 1'b0, 2'd1, 0);
      checks++; if (got_q.size() != 33 + HDR) begin errors++; $display("FAIL comp%0d_size got %0d want %0d", b, got_q.size(), 33 + HDR); end
      checks++; if (got_q[HDR] !== 8'(2 + b)) begin errors++; $display("FAIL comp%0d_prefix got %02h want %02h", b, got_q[HDR], 2 + b); end
      checks++; if (first_diff() != -1) begin errors++; $display("FAIL comp%0d_bytes first bad index %0d", b, first_diff()); end
      checks++; if (last_idx != 32 + HDR || len_seen !== CNT_W'(33 + HDR)) begin
        errors++; $display("FAIL comp%0d_last_len got %0d %0d want %0d %0d", b, last_idx, len_seen, 32 + HDR, 33 + HDR); end
`ifdef EC_POINT_ENCODER_LEN_HDR_EN
      checks++; if (got_q[0] !== 8'h00 || got_q[1] !== 8'h21) begin errors++; $display("FAIL comp%0d_hdr got %02h%02h want 0021", b, got_q[0], got_q[1]); end
`endif
    end
  endtask

  task automatic test_hybrid_stall();
    logic [W-1:0] x, y;
    x = rand_coord(); y = rand_coord(); y[0] = 1'b0;
    build_exp(x, y, 1'b0, 2'd2);
    encode(x, y, 1'b0, 2'd2, 1);
    checks++; if (got_q.size() != 65 + HDR) begin errors++; $display("FAIL hyb_size got %0d want %0d", got_q.size(), 65 + HDR); end
    checks++; if (got_q[HDR] !== 8'h06) begin errors++; $display("FAIL hyb_prefix got %02h want 06", got_q[HDR]); end
    checks++; if (first_diff() != -1) begin errors++; $display("FAIL hyb_bytes first bad index %0d", first_diff()); end
    checks++; if (stall_bad != 0 || bubble != 0) begin errors++; $display("FAIL hyb_stall got unstable %0d bubbles %0d want 0 0", stall_bad, bubble); end
    checks++; if (last_idx != 64 + HDR) begin errors++; $display("FAIL hyb_last got %0d want %0d", last_idx, 64 + HDR); end
  endtask

  task automatic test_infinity();
    int e0;
    e0 = err_seen;
    build_exp(rand_coord(), rand_coord(), 1'b1, 2'd3);
    encode(rand_coord(), rand_coord(), 1'b1, 2'd3, 0);
    repeat (2) @(negedge clk);
    checks++; if (got_q.size() != 1 + HDR || got_q[HDR] !== 8'h00) begin errors++; $display("FAIL inf_bytes got size %0d byte %02h want %0d 00", got_q.size(), got_q[HDR], 1 + HDR); end
    checks++; if (first_diff() != -1 || last_idx != HDR) begin errors++; $display("FAIL inf_last got %0d diff %0d want %0d", last_idx, first_diff(), HDR); end
    checks++; if (len_seen !== CNT_W'(1 + HDR)) begin errors++; $display("FAIL inf_len got %0d want %0d", len_seen, 1 + HDR); end
    checks++; if (err_seen != e0) begin errors++; $display("FAIL inf_err got %0d pulses want 0", err_seen - e0); end
  endtask

  task automatic test_reserved();
    int e0, vcnt, cyc;
    logic e1, r1, e2, r2;
    cyc = 0;
    while (!in_ready && cyc < 50) begin @(negedge clk); cyc++; end
    e0 = err_seen; vcnt = 0;
    in_valid = 1'b1; in_inf = 1'b0; in_fmt = 2'd3; in_x = rand_coord(); in_y = rand_coord();
    @(negedge clk);
    in_valid = 1'b0;
    e1 = err; r1 = in_ready; if (out_valid) vcnt++;
    @(negedge clk);
    e2 = err; r2 = in_ready; if (out_valid) vcnt++;
    repeat (3) begin @(negedge clk); if (out_valid) vcnt++; end
    checks++; if (e1 !== 1'b1 || r1 !== 1'b0) begin errors++; $display("FAIL rsv_err_pulse got err %0b ready %0b want 1 0", e1, r1); end
    checks++; if (e2 !== 1'b0 || r2 !== 1'b1) begin errors++; $display("FAIL rsv_recover got err %0b ready %0b want 0 1", e2, r2); end
    checks++; if (vcnt != 0 || err_seen - e0 != 1) begin errors++; $display("FAIL rsv_quiet got valids %0d pulses %0d want 0 1", vcnt, err_seen - e0); end
  endtask

  task automatic test_reset_midstream();
    logic [W-1:0] x, y;
    int cnt, k, vcnt;
    x = rand_coord(); y = rand_coord();
    k = 0;
    while (!in_ready && k < 50) begin @(negedge clk); k++; end
    in_valid = 1'b1; in_x = x; in_y = y; in_inf = 1'b0; in_fmt = 2'd0;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    cnt = 0; k = 0;
    while (cnt < 10 && k < 100) begin if (out_valid) cnt++; @(negedge clk); k++; end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b0;
    checks++; if (cnt != 10 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_last !== 1'b0) begin
      errors++; $display("FAIL midrst_state got bytes %0d valid %0b busy %0b ready %0b last %0b want 10 0 0 1 0", cnt, out_valid, busy, in_ready, out_last); end
    vcnt = 0;
    repeat (3) begin @(negedge clk); if (out_valid) vcnt++; end
    checks++; if (vcnt != 0) begin errors++; $display("FAIL midrst_quiet got %0d valid cycles want 0", vcnt); end
    x = rand_coord(); y = rand_coord();
    build_exp(x, y, 1'b0, 2'd0);
    encode(x, y, 1'b0, 2'd0, 0);
    checks++; if (got_q.size() != exp_q.size() || first_diff() != -1 || last_idx != exp_q.size() - 1) begin
      errors++; $display("FAIL midrst_next got size %0d diff %0d last %0d want %0d -1 %0d", got_q.size(), first_diff(), last_idx, exp_q.size(), exp_q.size() - 1); end
  endtask

  task automatic test_random();
    logic [W-1:0] x, y;
    logic inf;
    logic [1:0] fmt;
    int mode;
    for (int it = 0; it < 24; it++) begin
      x = rand_coord(); y = rand_coord();
      inf = ($urandom_range(0, 7) == 0);
      fmt = inf ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 2));
      mode = $urandom_range(0, 2);
      build_exp(x, y, inf, fmt);
      encode(x, y, inf, fmt, mode);
      checks++; if (timed_out || got_q.size() != exp_q.size() || first_diff() != -1) begin
        errors++; $display("FAIL rnd%0d_bytes got size %0d diff %0d want %0d -1 (fmt %0d inf %0b)", it, got_q.size(), first_diff(), exp_q.size(), fmt, inf); end
      checks++; if (last_idx != exp_q.size() - 1 || len_seen !== CNT_W'(exp_q.size()) || len_bad != 0) begin
        errors++; $display("FAIL rnd%0d_last_len got %0d %0d want %0d %0d", it, last_idx, len_seen, exp_q.size() - 1, exp_q.size()); end
      checks++; if (stall_bad != 0 || bubble != 0 || post_valid !== 1'b0 || post_ready !== 1'b1) begin
        errors++; $display("FAIL rnd%0d_hs got unstable %0d bubbles %0d post %0b%0b want 0 0 01", it, stall_bad, bubble, post_valid, post_ready); end
    end
  endtask

  initial begin
    test_reset();
    test_uncompressed();
    test_compressed();
    test_hybrid_stall();
    test_infinity();
    test_reserved();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
